// File: rtl/prog_loader.sv
// Byte-stream program loader: receives HDR, LEN, N instruction bytes and an XOR checksum,
// writes the words into program memory and holds the core in reset until a frame verifies.
module prog_loader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned INS_W  = 6,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              clr_err,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [INS_W-1:0]  pm_data,
  output logic              core_nReset,
  output logic              busy,
  output logic              loaded,
  output logic              err
);

  localparam int unsigned LenW     = ADDR_W + 1;
  localparam int unsigned MaxWords = 1 << ADDR_W;
  // Bits above the instruction field; any of them set marks a corrupt data byte.
  localparam logic [7:0]  HiMask   = 8'hFF << INS_W;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLen  = 3'd1;
  localparam logic [2:0] StData = 3'd2;
  localparam logic [2:0] StCsum = 3'd3;
  localparam logic [2:0] StErr  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   cnt_q, cnt_d;
  logic [LenW-1:0]   cnt_inc;
  logic [7:0]        csum_q, csum_d;
  logic              pm_we_q, pm_we_d;
  logic [ADDR_W-1:0] pm_addr_q, pm_addr_d;
  logic [INS_W-1:0]  pm_data_q, pm_data_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              loaded_q, loaded_d;
  logic              core_nreset_q, core_nreset_d;

  logic accept;
  logic hi_bad;
  logic len_ok;

  assign rx_ready = (state_q != StErr);
  assign accept   = rx_valid & rx_ready;
  assign hi_bad   = |(rx_data & HiMask);
  assign len_ok   = (rx_data != 8'd0) && (32'(rx_data) <= MaxWords);
  assign cnt_inc  = cnt_q + LenW'(1);

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    csum_d        = csum_q;
    pm_we_d       = 1'b0;
    pm_addr_d     = pm_addr_q;
    pm_data_d     = pm_data_q;
    busy_d        = busy_q;
    err_d         = err_q;
    loaded_d      = loaded_q;
    core_nreset_d = core_nreset_q;

    case (state_q)
      StIdle: begin
        // Non-header bytes are consumed and dropped so a stray stream cannot stall the link.
        if (accept && (rx_data == HDR)) begin
          state_d       = StLen;
          core_nreset_d = 1'b0;
          loaded_d      = 1'b0;
          busy_d        = 1'b1;
        end
      end

      StLen: begin
        if (accept) begin
          if (len_ok) begin
            len_d   = LenW'(rx_data);
            cnt_d   = '0;
            csum_d  = 8'h00;
            state_d = StData;
          end else begin
            state_d = StErr;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
      end

      StData: begin
        if (accept) begin
          if (hi_bad) begin
            state_d = StErr;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            pm_we_d   = 1'b1;
            pm_addr_d = cnt_q[ADDR_W-1:0];
            pm_data_d = rx_data[INS_W-1:0];
            csum_d    = csum_q ^ rx_data;
            cnt_d     = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = StCsum;
            end
          end
        end
      end

      StCsum: begin
        if (accept) begin
          busy_d = 1'b0;
          if (rx_data == csum_q) begin
            state_d       = StIdle;
            loaded_d      = 1'b1;
            core_nreset_d = 1'b1;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end

      StErr: begin
        if (clr_err) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= StIdle;
      len_q         <= '0;
      cnt_q         <= '0;
      csum_q        <= 8'h00;
      pm_we_q       <= 1'b0;
      pm_addr_q     <= '0;
      pm_data_q     <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      loaded_q      <= 1'b0;
      core_nreset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      csum_q        <= csum_d;
      pm_we_q       <= pm_we_d;
      pm_addr_q     <= pm_addr_d;
      pm_data_q     <= pm_data_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      loaded_q      <= loaded_d;
      core_nreset_q <= core_nreset_d;
    end
  end

  assign pm_we       = pm_we_q;
  assign pm_addr     = pm_addr_q;
  assign pm_data     = pm_data_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign loaded      = loaded_q;
  assign core_nReset = core_nreset_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level model queues expected writes and status,
// and a negedge monitor compares everything the DUT presents.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       Reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       clr_err;
  logic       pm_we;
  logic [4:0] pm_addr;
  logic [5:0] pm_data;
  logic       core_nReset;
  logic       busy;
  logic       loaded;
  logic       err;

  prog_loader #(
    .ADDR_W (5),
    .INS_W  (6),
    .HDR    (8'hA5)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .clr_err     (clr_err),
    .pm_we       (pm_we),
    .pm_addr     (pm_addr),
    .pm_data     (pm_data),
    .core_nReset (core_nReset),
    .busy        (busy),
    .loaded      (loaded),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    e;
    bit    l;
    bit    n;
    bit    b;
    bit    r;
    bit    rst;
  } stat_t;

  int         total = 0;
  int         bad = 0;
  int         timeouts = 0;
  bit         noise = 0;
  bit         final_req = 0;
  bit         done = 0;
  int         exp_addr[$];
  int         exp_data[$];
  stat_t      stat_q[$];
  stat_t      mon_s;
  logic [4:0] last_addr = '0;
  logic [5:0] last_data = '0;
  int         ea;
  int         ed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic expect_stat(input string name, input bit e, input bit l, input bit n,
                             input bit b, input bit r, input bit rst);
    stat_t s;
    s.name = name; s.e = e; s.l = l; s.n = n; s.b = b; s.r = r; s.rst = rst;
    stat_q.push_back(s);
  endtask

  // Monitor: the only process that compares.
  always @(negedge clk) begin
    if (stat_q.size() > 0) begin
      mon_s = stat_q.pop_front();
      check({mon_s.name, ".err"}, 32'(err), 32'(mon_s.e));
      check({mon_s.name, ".loaded"}, 32'(loaded), 32'(mon_s.l));
      check({mon_s.name, ".core_nReset"}, 32'(core_nReset), 32'(mon_s.n));
      check({mon_s.name, ".busy"}, 32'(busy), 32'(mon_s.b));
      check({mon_s.name, ".rx_ready"}, 32'(rx_ready), 32'(mon_s.r));
      if (mon_s.rst) begin
        check({mon_s.name, ".pm_we"}, 32'(pm_we), 32'd0);
        check({mon_s.name, ".pm_addr"}, 32'(pm_addr), 32'd0);
        check({mon_s.name, ".pm_data"}, 32'(pm_data), 32'd0);
      end
    end
    if (Reset) begin
      last_addr = '0;
      last_data = '0;
    end else if (pm_we) begin
      if (exp_addr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h want no write", pm_addr, pm_data);
      end else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        check("write_addr", 32'(pm_addr), 32'(ea));
        check("write_data", 32'(pm_data), 32'(ed));
      end
      last_addr = pm_addr;
      last_data = pm_data;
    end else begin
      check("hold_addr", 32'(pm_addr), 32'(last_addr));
      check("hold_data", 32'(pm_data), 32'(last_data));
    end
    if (final_req && !done) begin
      check("missing_writes", 32'(exp_addr.size()), 32'd0);
      check("pending_status", 32'(stat_q.size()), 32'd0);
      check("send_timeout", 32'(timeouts), 32'd0);
      done = 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      clr_err  = noise ? 1'($urandom % 2) : 1'b0;
      if (rx_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    clr_err  = 1'b0;
    if (!ok) timeouts++;
  endtask

  task automatic do_gap(input int mode);
    if (mode == 1) @(negedge clk);
    else if (mode == 2) repeat ($urandom % 3) @(negedge clk);
  endtask

  // In ERR: bytes must stall, then clr_err returns to IDLE.
  task automatic stall_and_clear();
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    expect_stat("err_stall", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    expect_stat("err_cleared", 0, 0, 0, 0, 1, 0);
  endtask

  // Frame-level reference: derive writes and final status from the byte list.
  task automatic run_frame(input logic [7:0] fr[$], input int gap);
    int n;
    logic [7:0] csum;
    send_byte(fr[0]);
    expect_stat("after_hdr", 0, 0, 0, 1, 1, 0);
    n = int'(fr[1]);
    do_gap(gap);
    send_byte(fr[1]);
    if (n == 0 || n > 32) begin
      expect_stat("bad_len", 1, 0, 0, 0, 0, 0);
      stall_and_clear();
      return;
    end
    csum = 8'h00;
    for (int i = 0; i < n; i++) begin
      do_gap(gap);
      if (fr[2 + i] >= 8'd64) begin
        send_byte(fr[2 + i]);
        expect_stat("bad_data", 1, 0, 0, 0, 0, 0);
        stall_and_clear();
        return;
      end
      exp_addr.push_back(i);
      exp_data.push_back(int'(fr[2 + i]) % 64);
      csum = csum ^ fr[2 + i];
      send_byte(fr[2 + i]);
    end
    do_gap(gap);
    send_byte(fr[2 + n]);
    if (fr[2 + n] == csum) begin
      expect_stat("loaded", 0, 1, 1, 0, 1, 0);
    end else begin
      expect_stat("bad_csum", 1, 0, 0, 0, 0, 0);
      stall_and_clear();
    end
  endtask

  task automatic rand_data_frame(input int n, output logic [7:0] fr[$]);
    logic [7:0] cs = 8'h00;
    logic [7:0] d;
    fr = {8'hA5, 8'(n)};
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom % 64);
      fr.push_back(d);
      cs = cs ^ d;
    end
    fr.push_back(cs);
  endtask

  initial begin
    logic [7:0] fr[$];
    int r;
    int n;
    logic [7:0] cs;
    logic [7:0] d;
    Reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    clr_err  = 1'b0;
    expect_stat("reset", 0, 0, 0, 0, 1, 1);
    repeat (2) @(negedge clk);
    #2 Reset = 1'b0;

    fr = {8'hA5, 8'h03, 8'h01, 8'h22, 8'h3F, 8'h1C};
    run_frame(fr, 0);
    fr = {8'hA5, 8'h02, 8'h05, 8'h06, 8'h00};
    run_frame(fr, 0);
    fr = {8'hA5, 8'h00};
    run_frame(fr, 0);
    fr = {8'hA5, 8'h21};
    run_frame(fr, 0);
    fr = {8'hA5, 8'h02, 8'h40};
    run_frame(fr, 0);

    rand_data_frame(32, fr);
    run_frame(fr, 0);
    repeat (4) send_byte(8'h11);
    expect_stat("after_full", 0, 1, 1, 0, 1, 0);

    rand_data_frame(8, fr);
    run_frame(fr, 1);

    // Reset pulse after the second data byte of a four-word frame.
    send_byte(8'hA5);
    send_byte(8'h04);
    exp_addr.push_back(0);
    exp_data.push_back(6'h15);
    send_byte(8'h15);
    exp_addr.push_back(1);
    exp_data.push_back(6'h2A);
    send_byte(8'h2A);
    @(negedge clk);
    #1 Reset = 1'b1;
    expect_stat("mid_reset", 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    #2 Reset = 1'b0;
    expect_stat("post_reset", 0, 0, 0, 0, 1, 1);
    repeat (3) @(negedge clk);
    rand_data_frame(4, fr);
    run_frame(fr, 0);

    noise = 1;
    for (int k = 0; k < 25; k++) begin
      r = int'($urandom % 10);
      if (r == 0) begin
        n = ($urandom % 2) != 0 ? 0 : 33 + int'($urandom % 223);
        fr = {8'hA5, 8'(n)};
      end else begin
        n = 1 + int'($urandom % 32);
        fr = {8'hA5, 8'(n)};
        cs = 8'h00;
        for (int i = 0; i < n; i++) begin
          d = 8'($urandom % 64);
          if (r == 1 && i == n / 2) d = 8'h40 | 8'($urandom % 256);
          fr.push_back(d);
          cs = cs ^ d;
        end
        if (r == 2) cs = cs ^ 8'(1 + $urandom % 255);
        fr.push_back(cs);
      end
      run_frame(fr, 2);
    end
    noise = 0;

    repeat (3) @(negedge clk);
    final_req = 1;
    wait (done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
